// File: rtl/pipe_datapath.sv
// Five-stage RV32I pipelined datapath with EX-stage forwarding, hazard unit and branch resolution.
// Control arrives decoded from InstrD and travels down the pipe in the stage registers.
module pipe_datapath #(
  parameter logic [31:0] RESET_PC = 32'h1000_0000,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic [31:0] ReadData,
  input  logic        RegWriteD,
  input  logic [1:0]  ResultSrcD,
  input  logic        MemWriteD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        JalrD,
  input  logic [4:0]  ALUControlD,
  input  logic [1:0]  ALUSrcAD,
  input  logic        ALUSrcBD,
  input  logic [2:0]  ImmSrcD,
  output logic [31:0] PC,
  output logic [31:0] InstrD,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [3:0]  ByteEnableM,
  output logic        MemWriteM,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE
);
  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [4:0] AluAdd = 5'd0, AluSub = 5'd1, AluAnd = 5'd2, AluOr = 5'd3,
                         AluXor = 5'd4, AluSlt = 5'd5, AluSltu = 5'd6, AluSll = 5'd7,
                         AluSrl = 5'd8, AluSra = 5'd9;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write, branch, jump, jalr;
    logic [4:0]  alu_control;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [31:0] rd1, rd2, pc, pc_plus4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
  } ex_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic [31:0] alu_result, write_data, pc_plus4;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result, read_data, pc_plus4;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } wb_t;

  logic [31:0] pc_q, pc_plus4_f, pc_target_e, instr_d_q, pc_d_q, pc_plus4_d_q;
  logic [31:0] rf [32];
  logic [31:0] rd1_d, rd2_d, imm_ext_d, result_w, load_w, load_shift_w;
  logic [31:0] fwd_a, fwd_b, src_a, src_b, alu_result_e;
  logic [32:0] diff_e;
  logic [4:0]  rs1_d, rs2_d;
  logic        pc_src_e, taken_e, flag_z, flag_n, flag_v, flag_c;
  logic        load_use, raw_hazard, hold;
  logic [3:0]  be_m;
  ex_t         ex_d, ex_q;
  mem_t        mem_q;
  wb_t         wb_q;

  // Fetch
  assign PC         = pc_q;
  assign pc_plus4_f = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else if (!StallF) pc_q <= pc_src_e ? pc_target_e : pc_plus4_f;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      instr_d_q    <= Nop;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
    end else if (!StallD) begin
      instr_d_q    <= Instr;
      pc_d_q       <= pc_q;
      pc_plus4_d_q <= pc_plus4_f;
    end
  end

  // Decode: register read is write-through from WB
  assign InstrD = instr_d_q;
  assign rs1_d  = instr_d_q[19:15];
  assign rs2_d  = instr_d_q[24:20];
  assign rd1_d  = (rs1_d == '0) ? '0 :
                  (wb_q.reg_write && wb_q.rd == rs1_d) ? result_w : rf[rs1_d];
  assign rd2_d  = (rs2_d == '0) ? '0 :
                  (wb_q.reg_write && wb_q.rd == rs2_d) ? result_w : rf[rs2_d];

  always_comb begin
    unique case (ImmSrcD)
      3'b000:  imm_ext_d = {{20{instr_d_q[31]}}, instr_d_q[31:20]};
      3'b001:  imm_ext_d = {{20{instr_d_q[31]}}, instr_d_q[31:25], instr_d_q[11:7]};
      3'b010:  imm_ext_d = {{19{instr_d_q[31]}}, instr_d_q[31], instr_d_q[7], instr_d_q[30:25],
                            instr_d_q[11:8], 1'b0};
      3'b011:  imm_ext_d = {{11{instr_d_q[31]}}, instr_d_q[31], instr_d_q[19:12], instr_d_q[20],
                            instr_d_q[30:21], 1'b0};
      3'b100:  imm_ext_d = {instr_d_q[31:12], 12'b0};
      default: imm_ext_d = '0;
    endcase
  end

  assign ex_d = '{reg_write: RegWriteD, result_src: ResultSrcD, mem_write: MemWriteD,
                  branch: BranchD, jump: JumpD, jalr: JalrD, alu_control: ALUControlD,
                  alu_src_a: ALUSrcAD, alu_src_b: ALUSrcBD, rd1: rd1_d, rd2: rd2_d,
                  pc: pc_d_q, pc_plus4: pc_plus4_d_q, imm: imm_ext_d, rs1: rs1_d, rs2: rs2_d,
                  rd: instr_d_q[11:7], funct3: instr_d_q[14:12]};

  always_ff @(posedge clk) begin
    if (rst || FlushE) ex_q <= '0;
    else ex_q <= ex_d;
  end

  // Execute: MEM result outranks WB result when both match
  always_comb begin
    fwd_a = ex_q.rd1;
    fwd_b = ex_q.rd2;
    if (FWD_EN && mem_q.reg_write && mem_q.rd != '0 && mem_q.rd == ex_q.rs1)
      fwd_a = mem_q.alu_result;
    else if (FWD_EN && wb_q.reg_write && wb_q.rd != '0 && wb_q.rd == ex_q.rs1)
      fwd_a = result_w;
    if (FWD_EN && mem_q.reg_write && mem_q.rd != '0 && mem_q.rd == ex_q.rs2)
      fwd_b = mem_q.alu_result;
    else if (FWD_EN && wb_q.reg_write && wb_q.rd != '0 && wb_q.rd == ex_q.rs2)
      fwd_b = result_w;
  end

  always_comb begin
    case (ex_q.alu_src_a)
      2'b01:   src_a = ex_q.pc;
      2'b10:   src_a = '0;
      default: src_a = fwd_a;
    endcase
    src_b = ex_q.alu_src_b ? ex_q.imm : fwd_b;
    case (ex_q.alu_control)
      AluSub:  alu_result_e = src_a - src_b;
      AluAnd:  alu_result_e = src_a & src_b;
      AluOr:   alu_result_e = src_a | src_b;
      AluXor:  alu_result_e = src_a ^ src_b;
      AluSlt:  alu_result_e = {31'b0, $signed(src_a) < $signed(src_b)};
      AluSltu: alu_result_e = {31'b0, src_a < src_b};
      AluSll:  alu_result_e = src_a << src_b[4:0];
      AluSrl:  alu_result_e = src_a >> src_b[4:0];
      AluSra:  alu_result_e = $signed(src_a) >>> src_b[4:0];
      AluAdd:  alu_result_e = src_a + src_b;
      default: alu_result_e = src_a + src_b;
    endcase
  end

  // Branch flags from a - b; carry set means no borrow
  assign diff_e = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
  assign flag_c = diff_e[32];
  assign flag_n = diff_e[31];
  assign flag_z = (diff_e[31:0] == '0);
  assign flag_v = (src_a[31] != src_b[31]) && (diff_e[31] != src_a[31]);

  always_comb begin
    case (ex_q.funct3)
      3'b000:  taken_e = flag_z;
      3'b001:  taken_e = !flag_z;
      3'b100:  taken_e = flag_n ^ flag_v;
      3'b101:  taken_e = !(flag_n ^ flag_v);
      3'b110:  taken_e = !flag_c;
      3'b111:  taken_e = flag_c;
      default: taken_e = 1'b0;
    endcase
  end

  assign pc_src_e    = (ex_q.branch & taken_e) | ex_q.jump | ex_q.jalr;
  assign pc_target_e = ex_q.jalr ? (alu_result_e & ~32'h1) : (ex_q.pc + ex_q.imm);

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else mem_q <= '{reg_write: ex_q.reg_write, result_src: ex_q.result_src,
                    mem_write: ex_q.mem_write, alu_result: alu_result_e, write_data: fwd_b,
                    pc_plus4: ex_q.pc_plus4, rd: ex_q.rd, funct3: ex_q.funct3};
  end

  // Memory: store lane alignment
  assign ALUResultM = mem_q.alu_result;
  always_comb begin
    case (mem_q.funct3)
      3'b000: begin
        be_m       = 4'b0001 << mem_q.alu_result[1:0];
        WriteDataM = {4{mem_q.write_data[7:0]}};
      end
      3'b001: begin
        be_m       = mem_q.alu_result[1] ? 4'b1100 : 4'b0011;
        WriteDataM = {2{mem_q.write_data[15:0]}};
      end
      default: begin
        be_m       = 4'b1111;
        WriteDataM = mem_q.write_data;
      end
    endcase
  end
  assign MemWriteM   = mem_q.mem_write & ~rst;
  assign ByteEnableM = MemWriteM ? be_m : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else wb_q <= '{reg_write: mem_q.reg_write, result_src: mem_q.result_src,
                   alu_result: mem_q.alu_result, read_data: ReadData,
                   pc_plus4: mem_q.pc_plus4, rd: mem_q.rd, funct3: mem_q.funct3};
  end

  // Writeback: load lane extraction and result select
  assign load_shift_w = wb_q.read_data >> {wb_q.alu_result[1:0], 3'b000};
  always_comb begin
    case (wb_q.funct3)
      3'b000:  load_w = {{24{load_shift_w[7]}}, load_shift_w[7:0]};
      3'b001:  load_w = {{16{load_shift_w[15]}}, load_shift_w[15:0]};
      3'b100:  load_w = {24'b0, load_shift_w[7:0]};
      3'b101:  load_w = {16'b0, load_shift_w[15:0]};
      default: load_w = load_shift_w;
    endcase
    case (wb_q.result_src)
      2'b01:   result_w = load_w;
      2'b10:   result_w = wb_q.pc_plus4;
      default: result_w = wb_q.alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_q.reg_write && wb_q.rd != '0) rf[wb_q.rd] <= result_w;
  end

  // Hazards: a redirect overrides any stall so the target is fetched next cycle
  always_comb begin
    load_use   = (ex_q.result_src == 2'b01) && (ex_q.rd != '0) &&
                 (ex_q.rd == rs1_d || ex_q.rd == rs2_d);
    raw_hazard = (rs1_d != '0 && ((ex_q.reg_write && rs1_d == ex_q.rd) ||
                                  (mem_q.reg_write && rs1_d == mem_q.rd))) ||
                 (rs2_d != '0 && ((ex_q.reg_write && rs2_d == ex_q.rd) ||
                                  (mem_q.reg_write && rs2_d == mem_q.rd)));
    hold       = FWD_EN ? load_use : raw_hazard;
    StallF     = hold & ~pc_src_e & ~rst;
    StallD     = hold & ~pc_src_e & ~rst;
    FlushD     = pc_src_e & ~rst;
    FlushE     = (pc_src_e | hold) & ~rst;
  end
endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: forwarding and stalling instances share one program memory;
// the bench decodes InstrD for each instance and models a byte-enabled data memory.
module tb_pipe_datapath;
  typedef struct packed {
    logic rw; logic [1:0] rs; logic mw, br, jp, jr;
    logic [4:0] alu; logic [1:0] sa; logic sb; logic [2:0] is;
  } ctl_t;

  logic clk, rst;
  logic [31:0] imem [64];
  logic [31:0] dmem_f [256];
  logic [31:0] dmem_s [256];
  logic [31:0] pc_f, pc_s, instr_f, instr_s, instr_d_f, instr_d_s, rdata_f, rdata_s;
  logic [31:0] alu_f, alu_s, wd_f, wd_s;
  logic [3:0]  be_f, be_s;
  logic        mw_f, mw_s, stf_f, std_f, fd_f, fe_f, stf_s, std_s, fd_s, fe_s;
  ctl_t        ctl_f, ctl_s;

  int errors = 0, checks = 0;
  int mw_cnt_f, mw_cnt_s, stf_cnt_f, std_cnt_f, fd_cnt_f, fe_cnt_f, stf_cnt_s;
  logic        pend_f;
  logic [31:0] pc_after_f, wd_cap, addr_cap;
  logic [3:0]  be_cap;

  function automatic ctl_t decode(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    case (ins[6:0])
      7'h13: begin c.rw = 1'b1; c.sb = 1'b1; end
      7'h33: c.rw = 1'b1;
      7'h03: begin c.rw = 1'b1; c.rs = 2'b01; c.sb = 1'b1; end
      7'h23: begin c.mw = 1'b1; c.sb = 1'b1; c.is = 3'b001; end
      7'h63: begin c.br = 1'b1; c.alu = 5'd1; c.is = 3'b010; end
      7'h6f: begin c.jp = 1'b1; c.rw = 1'b1; c.rs = 2'b10; c.is = 3'b011; end
      7'h67: begin c.jr = 1'b1; c.rw = 1'b1; c.rs = 2'b10; c.sb = 1'b1; end
      7'h37: begin c.rw = 1'b1; c.sa = 2'b10; c.sb = 1'b1; c.is = 3'b100; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] store(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h67};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  assign instr_f = imem[6'((pc_f - 32'h1000_0000) >> 2)];
  assign instr_s = imem[6'((pc_s - 32'h1000_0000) >> 2)];
  assign rdata_f = dmem_f[alu_f[9:2]];
  assign rdata_s = dmem_s[alu_s[9:2]];
  assign ctl_f   = decode(instr_d_f);
  assign ctl_s   = decode(instr_d_s);

  pipe_datapath #(.RESET_PC(32'h1000_0000), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .Instr(instr_f), .ReadData(rdata_f),
    .RegWriteD(ctl_f.rw), .ResultSrcD(ctl_f.rs), .MemWriteD(ctl_f.mw), .BranchD(ctl_f.br),
    .JumpD(ctl_f.jp), .JalrD(ctl_f.jr), .ALUControlD(ctl_f.alu), .ALUSrcAD(ctl_f.sa),
    .ALUSrcBD(ctl_f.sb), .ImmSrcD(ctl_f.is), .PC(pc_f), .InstrD(instr_d_f),
    .ALUResultM(alu_f), .WriteDataM(wd_f), .ByteEnableM(be_f), .MemWriteM(mw_f),
    .StallF(stf_f), .StallD(std_f), .FlushD(fd_f), .FlushE(fe_f)
  );

  pipe_datapath #(.RESET_PC(32'h1000_0000), .FWD_EN(1'b0)) u_stl (
    .clk(clk), .rst(rst), .Instr(instr_s), .ReadData(rdata_s),
    .RegWriteD(ctl_s.rw), .ResultSrcD(ctl_s.rs), .MemWriteD(ctl_s.mw), .BranchD(ctl_s.br),
    .JumpD(ctl_s.jp), .JalrD(ctl_s.jr), .ALUControlD(ctl_s.alu), .ALUSrcAD(ctl_s.sa),
    .ALUSrcBD(ctl_s.sb), .ImmSrcD(ctl_s.is), .PC(pc_s), .InstrD(instr_d_s),
    .ALUResultM(alu_s), .WriteDataM(wd_s), .ByteEnableM(be_s), .MemWriteM(mw_s),
    .StallF(stf_s), .StallD(std_s), .FlushD(fd_s), .FlushE(fe_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < 256; i++) begin dmem_f[i] = '0; dmem_s[i] = '0; end
  endtask

  task automatic clear_stats();
    mw_cnt_f = 0; mw_cnt_s = 0; stf_cnt_f = 0; std_cnt_f = 0; fd_cnt_f = 0; fe_cnt_f = 0;
    stf_cnt_s = 0; pend_f = 1'b0; pc_after_f = '0; wd_cap = '0; addr_cap = '0; be_cap = '0;
  endtask

  // Called once per cycle, #1 after the rising edge: applies stores and tallies hazards.
  task automatic sample();
    if (mw_f) begin
      for (int b = 0; b < 4; b++) if (be_f[b]) dmem_f[alu_f[9:2]][8*b +: 8] = wd_f[8*b +: 8];
      if (mw_cnt_f == 0) begin be_cap = be_f; wd_cap = wd_f; addr_cap = alu_f; end
      mw_cnt_f++;
    end
    if (mw_s) begin
      for (int b = 0; b < 4; b++) if (be_s[b]) dmem_s[alu_s[9:2]][8*b +: 8] = wd_s[8*b +: 8];
      mw_cnt_s++;
    end
    if (pend_f) begin pc_after_f = pc_f; pend_f = 1'b0; end
    if (fd_f && fd_cnt_f == 0) pend_f = 1'b1;
    if (stf_f) stf_cnt_f++;
    if (std_f) std_cnt_f++;
    if (fd_f) fd_cnt_f++;
    if (fe_f) fe_cnt_f++;
    if (stf_s) stf_cnt_s++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin step(); sample(); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    clear_stats();
    sample();
  endtask

  initial begin
    rst = 1'b1;
    clear_mem();
    clear_stats();

    // Reset: PC sequence, nop in ID, no stores, hazards idle
    do_reset();
    check("rst_pc0", pc_f, 32'h1000_0000);
    check("rst_pc0_stl", pc_s, 32'h1000_0000);
    check("rst_instrd", instr_d_f, 32'h0000_0013);
    check("rst_be", {28'b0, be_f}, 32'h0);
    check("rst_hazard", {28'b0, stf_f, std_f, fd_f, fe_f}, 32'h0);
    check("rst_hazard_stl", {28'b0, stf_s, std_s, fd_s, fe_s}, 32'h0);
    run(1);
    check("rst_pc1", pc_f, 32'h1000_0004);
    run(1);
    check("rst_pc2", pc_f, 32'h1000_0008);
    run(3);
    check("rst_no_store", mw_cnt_f + mw_cnt_s, 32'd0);

    // Forwarding versus stalling on a RAW chain
    clear_mem();
    imem[0] = addi(5'd1, 5'd0, 12'd5);
    imem[1] = addi(5'd2, 5'd1, 12'd3);
    imem[2] = add(5'd3, 5'd1, 5'd2);
    imem[7] = store(3'b010, 5'd3, 12'h040);
    do_reset();
    run(25);
    check("fwd_x3", dmem_f[16], 32'd13);
    check("fwd_stalls", stf_cnt_f, 32'd0);
    check("stl_x3", dmem_s[16], 32'd13);
    check("stl_stalls", stf_cnt_s, 32'd4);

    // Load-use bubble
    clear_mem();
    imem[0] = lui(5'd5, 20'h00001);
    imem[1] = addi(5'd5, 5'd5, 12'h234);
    imem[2] = store(3'b010, 5'd5, 12'h100);
    imem[3] = lw(5'd6, 12'h100);
    imem[4] = addi(5'd7, 5'd6, 12'd1);
    imem[8] = store(3'b010, 5'd7, 12'h104);
    do_reset();
    run(25);
    check("lu_mem100", dmem_f[64], 32'h0000_1234);
    check("lu_x7", dmem_f[65], 32'h0000_1235);
    check("lu_stallf", stf_cnt_f, 32'd1);
    check("lu_stalld", std_cnt_f, 32'd1);
    check("lu_flushe", fe_cnt_f, 32'd1);
    check("lu_x7_stl", dmem_s[65], 32'h0000_1235);

    // Taken branch squashes two wrong-path writes
    clear_mem();
    imem[0] = addi(5'd9, 5'd0, 12'd1);
    imem[1] = addi(5'd10, 5'd0, 12'd2);
    imem[2] = beq(5'd0, 5'd0, 13'd16);
    imem[3] = addi(5'd9, 5'd0, 12'h077);
    imem[4] = addi(5'd10, 5'd0, 12'h066);
    imem[9] = store(3'b010, 5'd9, 12'h080);
    imem[10] = store(3'b010, 5'd10, 12'h084);
    do_reset();
    run(25);
    check("br_flushd", fd_cnt_f, 32'd1);
    check("br_flushe", fe_cnt_f, 32'd1);
    check("br_target", pc_after_f, 32'h1000_0018);
    check("br_x9", dmem_f[32], 32'd1);
    check("br_x10", dmem_f[33], 32'd2);

    // jalr: x1 set by a first run, kept across reset
    clear_mem();
    imem[0] = lui(5'd1, 20'h10000);
    imem[1] = addi(5'd1, 5'd1, 12'h021);
    do_reset();
    run(12);
    clear_mem();
    imem[0] = jalr(5'd4, 5'd1, 12'd0);
    imem[11] = store(3'b010, 5'd4, 12'h0C0);
    do_reset();
    run(25);
    check("jalr_target", pc_after_f, 32'h1000_0020);
    check("jalr_x4", dmem_f[48], 32'h1000_0004);
    check("jalr_x4_stl", dmem_s[48], 32'h1000_0004);

    // Store byte alignment
    clear_mem();
    imem[0] = addi(5'd8, 5'd0, 12'h0AB);
    imem[1] = store(3'b000, 5'd8, 12'h103);
    do_reset();
    run(20);
    check("sb_count", mw_cnt_f, 32'd1);
    check("sb_be", {28'b0, be_cap}, 32'h8);
    check("sb_lane3", {24'b0, wd_cap[31:24]}, 32'hAB);
    check("sb_addr", addr_cap, 32'h0000_0103);
    check("sb_mem", dmem_f[64], 32'hAB00_0000);

    // Reset mid-stream blocks stores immediately
    clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = store(3'b010, 5'd0, 12'h1F0);
    do_reset();
    run(4);
    check("mr_store_live", {31'b0, mw_f}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_rst_cycle", {30'b0, mw_f, mw_s}, 32'd0);
    step();
    check("mr_after", {30'b0, mw_f, mw_s}, 32'd0);
    check("mr_pc", pc_f, 32'h1000_0000);
    rst = 1'b0;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
